ball_move_arbiter: RTL
======================

Name: ball_move_arbiter

Overview:
- Controller ahead of the ball-position datapath. Turns raw joystick button vectors from two players, or an autonomous demo pattern, into one-step move commands.
- Paces commands with an internal tick prescaler and shares the single ball between player A and player B using round-robin arbitration.
- Issues each step over a valid/ready handshake.

Parameters:
- TICK_DIV, 524288, clock cycles per move tick (>=2).
- IDLE_TICKS, 256, consecutive request-free ticks before demo mode engages (>=1).
- HOR_FIELD, 799, horizontal field extent in pixels.
- VER_FIELD, 599, vertical field extent in pixels.
- SIZE, 25, ball edge length in pixels.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  high = ticks advance and new steps are arbitrated.
- control_a  in  4  player A buttons, active-low: [3]=up, [0]=down, [1]=left, [2]=right.
- control_b  in  4  player B buttons, same encoding.
- hor_pos  in  12  current ball x, fed back from the datapath.
- ver_pos  in  11  current ball y, fed back from the datapath.
- step_ready  in  1  datapath accepts the step on a rising edge when high.
- step_valid  out  1  step command pending.
- step_dx  out  2  two's complement x delta: 01=+1, 11=-1, 00=0.
- step_dy  out  2  two's complement y delta, same encoding.
- grant  out  2  01=A, 10=B, 00=demo (meaningful only while step_valid).
- demo_active  out  1  demo mode engaged.
- tick  out  1  one-cycle move-tick pulse.
- overrun  out  1  sticky: a tick arrived while a step was still pending.

Behaviour:
- Reset (reset=0 at an edge):
  - All outputs 0; prescaler 0; idle counter 0.
  - Round-robin pointer "last=B", so A wins the first contest.
  - Demo direction dx=+1, dy=+1; FSM in IDLE.
- Prescaler:
  - Increments while enable=1 and holds while enable=0.
  - At count TICK_DIV-1 it wraps to 0, and tick=1 for the following cycle.
  - Tick period is TICK_DIV cycles.
- Per-player decode (combinational, after inverting the buttons):
  - left gives dx=+1, right gives dx=-1, up gives dy=+1, down gives dy=-1.
  - Opposing buttons pressed together cancel that axis to 0.
  - A player requests only if the resulting (dx,dy) is nonzero.
- FSM states: IDLE, ISSUE.
- IDLE, on an edge with tick=1 and enable=1, evaluate in this order:
  - If any player requests:
    - Clear the idle counter and demo_active.
    - One requester: grant it. Both: grant the one not in last, then update last.
    - Load step_dx/dy/grant, set step_valid=1, go to ISSUE.
  - Else, if demo_active=1:
    - Update the demo direction first:
      - dx=+1 and hor_pos+SIZE >= HOR_FIELD-1: flip dx to -1.
      - dx=-1 and hor_pos <= 1: flip dx to +1.
      - dy uses the same rules with ver_pos/VER_FIELD.
    - Issue with the updated direction and grant=00, go to ISSUE.
    - Compare in 13 bits, with no truncation.
  - Else: increment the idle counter, saturating at IDLE_TICKS. Reaching IDLE_TICKS sets demo_active=1.
    - The first demo step issues on the next tick, not the one that set the flag.
- Latency: step_valid rises on the edge that samples tick=1, i.e. visible the cycle right after the tick cycle.
- ISSUE:
  - step_valid, step_dx, step_dy and grant stay stable until an edge with step_ready=1.
  - At that edge step_valid goes to 0 and the FSM returns to IDLE.
  - Back-to-back steps are impossible, because ticks are at least 2 cycles apart.
- Overrun:
  - A tick sampled while in ISSUE sets overrun=1, held until reset.
  - That tick is dropped: no arbitration, no idle count.
- enable=0:
  - No new arbitration; the prescaler freezes.
  - A pending ISSUE still completes normally.
- Buttons are sampled only on tick edges; changes between ticks are ignored.
- Reset mid-ISSUE: step_valid drops on that edge with no handshake.

Test Plan:
- TICK_DIV=4, reset released, enable=1, no buttons -> tick pulses every 4 cycles, step_valid stays 0, demo_active stays 0 for the first IDLE_TICKS-1 ticks.
- control_a=4'b1101 (left), step_ready=1 -> one cycle after the tick: step_valid=1, step_dx=01, step_dy=00, grant=01; step_valid=0 on the next cycle.
- Both players press up on three successive ticks -> grants are A, B, A; step_dy=01 each time.
- control_a=4'b0110 (up+down) with B idle -> no request; the idle counter advances.
- IDLE_TICKS=3 with no input -> demo_active=1 after the 3rd tick. With hor_pos=773 (>=798-25), the 4th tick issues step_dx=11, step_dy=01, grant=00.
- step_ready held 0 across the next tick -> step_valid stays 1 with dx/dy stable and overrun=1. Raising step_ready completes the step; overrun remains 1 until reset=0.

Source files
------------

// File: rtl/ball_move_arbiter.sv
// Paces joystick or demo-pattern requests into one-step ball moves, sharing the
// ball between two players with round-robin arbitration and a valid/ready handshake.
module ball_move_arbiter #(
    parameter int TICK_DIV   = 524288,
    parameter int IDLE_TICKS = 256,
    parameter int HOR_FIELD  = 799,
    parameter int VER_FIELD  = 599,
    parameter int SIZE       = 25
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  control_a,
    input  logic [3:0]  control_b,
    input  logic [11:0] hor_pos,
    input  logic [10:0] ver_pos,
    input  logic        step_ready,
    output logic        step_valid,
    output logic [1:0]  step_dx,
    output logic [1:0]  step_dy,
    output logic [1:0]  grant,
    output logic        demo_active,
    output logic        tick,
    output logic        overrun
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int IW = $clog2(IDLE_TICKS + 1);

    typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg;
    logic           tick_reg;
    logic           valid_reg, valid_next;
    logic [1:0]     dx_reg, dx_next;
    logic [1:0]     dy_reg, dy_next;
    logic [1:0]     grant_reg, grant_next;
    logic           last_b_reg, last_b_next;
    logic [IW-1:0]  idle_reg, idle_next;
    logic           demo_reg, demo_next;
    logic           ddx_neg_reg, ddx_neg_next;
    logic           ddy_neg_reg, ddy_neg_next;
    logic           overrun_reg, overrun_next;

    // Per-player decode: index 0 is player A, index 1 is player B.
    logic [3:0] ctrl [2];
    logic [1:0] req_dx [2];
    logic [1:0] req_dy [2];
    logic [1:0] req;

    assign ctrl[0] = control_a;
    assign ctrl[1] = control_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_player
            logic [3:0] pressed;
            assign pressed = ~ctrl[gi];
            always_comb begin
                req_dx[gi] = 2'b00;
                req_dy[gi] = 2'b00;
                if (pressed[1] && !pressed[2])
                    req_dx[gi] = 2'b01;
                else if (pressed[2] && !pressed[1])
                    req_dx[gi] = 2'b11;
                if (pressed[3] && !pressed[0])
                    req_dy[gi] = 2'b01;
                else if (pressed[0] && !pressed[3])
                    req_dy[gi] = 2'b11;
            end
            assign req[gi] = (req_dx[gi] != 2'b00) || (req_dy[gi] != 2'b00);
        end
    endgenerate

    // Widened so the edge tests never wrap.
    logic [12:0] hor_ext, ver_ext;
    assign hor_ext = {1'b0, hor_pos};
    assign ver_ext = {2'b00, ver_pos};

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= 1'b0;
            if (enable) begin
                if (cnt_reg == CW'(TICK_DIV - 1)) begin
                    cnt_reg  <= '0;
                    tick_reg <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            valid_reg   <= 1'b0;
            dx_reg      <= 2'b00;
            dy_reg      <= 2'b00;
            grant_reg   <= 2'b00;
            last_b_reg  <= 1'b1;
            idle_reg    <= '0;
            demo_reg    <= 1'b0;
            ddx_neg_reg <= 1'b0;
            ddy_neg_reg <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            valid_reg   <= valid_next;
            dx_reg      <= dx_next;
            dy_reg      <= dy_next;
            grant_reg   <= grant_next;
            last_b_reg  <= last_b_next;
            idle_reg    <= idle_next;
            demo_reg    <= demo_next;
            ddx_neg_reg <= ddx_neg_next;
            ddy_neg_reg <= ddy_neg_next;
            overrun_reg <= overrun_next;
        end
    end

    logic sel_b;
    logic flip_x, flip_y;

    always_comb begin
        state_next   = state_reg;
        valid_next   = valid_reg;
        dx_next      = dx_reg;
        dy_next      = dy_reg;
        grant_next   = grant_reg;
        last_b_next  = last_b_reg;
        idle_next    = idle_reg;
        demo_next    = demo_reg;
        ddx_neg_next = ddx_neg_reg;
        ddy_neg_next = ddy_neg_reg;
        overrun_next = overrun_reg;

        // A contest goes to whoever did not win the previous contest.
        sel_b  = req[1] && (!req[0] || !last_b_reg);
        flip_x = ddx_neg_reg ? (hor_ext <= 13'd1)
                             : (hor_ext + 13'(SIZE) >= 13'(HOR_FIELD - 1));
        flip_y = ddy_neg_reg ? (ver_ext <= 13'd1)
                             : (ver_ext + 13'(SIZE) >= 13'(VER_FIELD - 1));

        case (state_reg)
            ST_IDLE: begin
                if (tick_reg && enable) begin
                    if (req != 2'b00) begin
                        idle_next  = '0;
                        demo_next  = 1'b0;
                        if (req == 2'b11)
                            last_b_next = sel_b;
                        dx_next    = sel_b ? req_dx[1] : req_dx[0];
                        dy_next    = sel_b ? req_dy[1] : req_dy[0];
                        grant_next = sel_b ? 2'b10 : 2'b01;
                        valid_next = 1'b1;
                        state_next = ST_ISSUE;
                    end else if (demo_reg) begin
                        ddx_neg_next = ddx_neg_reg ^ flip_x;
                        ddy_neg_next = ddy_neg_reg ^ flip_y;
                        dx_next      = ddx_neg_next ? 2'b11 : 2'b01;
                        dy_next      = ddy_neg_next ? 2'b11 : 2'b01;
                        grant_next   = 2'b00;
                        valid_next   = 1'b1;
                        state_next   = ST_ISSUE;
                    end else if (idle_reg < IW'(IDLE_TICKS)) begin
                        idle_next = idle_reg + 1'b1;
                        if (idle_next == IW'(IDLE_TICKS))
                            demo_next = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (tick_reg)
                    overrun_next = 1'b1;
                if (step_ready) begin
                    valid_next = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign step_valid  = valid_reg;
    assign step_dx     = dx_reg;
    assign step_dy     = dy_reg;
    assign grant       = grant_reg;
    assign demo_active = demo_reg;
    assign tick        = tick_reg;
    assign overrun     = overrun_reg;
endmodule
